// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx : parallel-in / serial-out transmitter with a one-word skid buffer.
//
// A word offered on data_in/data_valid is captured into a holding register
// whenever that register is empty (data_ready). The shifter pulls from the
// holding register at frame start, so a second word can wait while the first
// is being serialised and the two frames run back to back with no idle gap.
// Bits leave MSB first on a registered output; an optional even-parity bit
// follows the data bits.
//
// Parameters
//   SIZE       data word width in bits (SIZE >= 2)
//   PARITY_EN  1 = append one even-parity bit to every frame
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   enable      shift advance qualifier (frame FSM holds while low)
//   data_in     parallel word to transmit
//   data_valid  data_in is valid
//   data_ready  holding register is empty and can accept a word
//   out         registered serial bit stream, MSB first
//   done        one-cycle pulse on the edge that completes a frame
//   busy        a frame is in progress
// ---------------------------------------------------------------------------
module piso_tx #(
    parameter int SIZE      = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [SIZE-1:0] data_in,
    input  logic            data_valid,
    output logic            data_ready,
    output logic            out,
    output logic            done,
    output logic            busy
);

    localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state_r;
    logic [SIZE-1:0]   hold_reg_r;
    logic              hold_full_r;
    logic [SIZE-1:0]   shift_reg_r;
    logic [CNT_W-1:0]  bit_count_r;
    logic              parity_r;

    logic              accept_s;
    logic              frame_end_s;
    logic              load_s;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [SIZE-1:0] word);
        even_parity = ^word;
    endfunction

    // Ready depends only on the holding register, never on data_valid or enable.
    assign data_ready = ~hold_full_r;

    // Per-edge decisions: capture a new word, finish a frame, start a frame.
    always_comb begin
        accept_s    = 1'b0;
        frame_end_s = 1'b0;
        load_s      = 1'b0;

        accept_s = data_valid & ~hold_full_r;

        if (enable) begin
            case (state_r)
                SHIFT: begin
                    if ((bit_count_r == LAST_BIT) && (PARITY_EN == 1'b0)) begin
                        frame_end_s = 1'b1;
                    end else begin
                        frame_end_s = 1'b0;
                    end
                end
                PARITY:  frame_end_s = 1'b1;
                IDLE:    frame_end_s = 1'b0;
                default: frame_end_s = 1'b0;
            endcase
        end else begin
            frame_end_s = 1'b0;
        end

        // A load happens from idle, or chained onto a frame end so the next
        // frame follows without a gap. It needs a full holding register, so it
        // can never coincide with an acceptance.
        if (enable && hold_full_r && ((state_r == IDLE) || frame_end_s)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Frame FSM, holding register, shifter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            hold_reg_r  <= {SIZE{1'b0}};
            hold_full_r <= 1'b0;
            shift_reg_r <= {SIZE{1'b0}};
            bit_count_r <= {CNT_W{1'b0}};
            parity_r    <= 1'b0;
            out         <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= frame_end_s;

            if (load_s) begin
                hold_full_r <= 1'b0;
            end else if (accept_s) begin
                hold_reg_r  <= data_in;
                hold_full_r <= 1'b1;
            end

            if (load_s) begin
                // The MSB goes straight to out; the shifter keeps the rest.
                out         <= hold_reg_r[SIZE-1];
                shift_reg_r <= hold_reg_r << 1;
                bit_count_r <= {CNT_W{1'b0}};
                parity_r    <= even_parity(hold_reg_r);
                busy        <= 1'b1;
                state_r     <= SHIFT;
            end else if (frame_end_s) begin
                out     <= 1'b0;
                busy    <= 1'b0;
                state_r <= IDLE;
            end else if (enable && (state_r == SHIFT)) begin
                // Reaching the last data bit here implies parity is enabled.
                if (bit_count_r == LAST_BIT) begin
                    out     <= parity_r;
                    state_r <= PARITY;
                end else begin
                    out         <= shift_reg_r[SIZE-1];
                    shift_reg_r <= shift_reg_r << 1;
                    bit_count_r <= bit_count_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx : directed self-checking bench for piso_tx (SIZE=8).
// Two instances share the stimulus: u_dut0 without parity, u_dut1 with parity.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_piso_tx;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic       data_valid;

    logic data_ready0, out0, done0, busy0;
    logic data_ready1, out1, done1, busy1;

    int tests;
    int fails;

    piso_tx #(.SIZE(8), .PARITY_EN(1'b0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready0),
        .out        (out0),
        .done       (done0),
        .busy       (busy0)
    );

    piso_tx #(.SIZE(8), .PARITY_EN(1'b1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready1),
        .out        (out1),
        .done       (done1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        enable     = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        tests++;
        if ({out0, done0, busy0, data_ready0} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_dut0 got=%b exp=0001", {out0, done0, busy0, data_ready0});
        end
        tests++;
        if ({out1, done1, busy1, data_ready1} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_dut1 got=%b exp=0001", {out1, done1, busy1, data_ready1});
        end
    endtask

    task automatic test_basic;
        logic [7:0] w;
        w = 8'hA5;
        do_reset;
        enable = 1'b1; data_in = w; data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        tests++;
        if (data_ready0 !== 1'b0) begin
            fails++; $display("FAIL basic_ready got=%b exp=0", data_ready0);
        end
        for (int i = 7; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {w[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL basic_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {w[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b001) begin
            fails++; $display("FAIL basic_done got=%b exp=001", {out0, busy0, done0});
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b000) begin
            fails++; $display("FAIL basic_after got=%b exp=000", {out0, busy0, done0});
        end
    endtask

    task automatic test_parity;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hA5; b = 8'h07;
        do_reset;
        enable = 1'b1; data_in = a; data_valid = 1'b1;
        tick;
        data_in = b;
        for (int i = 7; i >= 0; i--) begin
            tick;
            if (i == 6) data_valid = 1'b0;
            tests++;
            if ({out1, busy1, done1} !== {a[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL par_a_bit%0d got=%b exp=%b", i, {out1, busy1, done1}, {a[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out1, busy1, done1} !== 3'b010) begin
            fails++; $display("FAIL par_a_parity got=%b exp=010", {out1, busy1, done1});
        end
        tick;
        tests++;
        if ({out1, busy1, done1} !== {b[7], 1'b1, 1'b1}) begin
            fails++; $display("FAIL par_a_done got=%b exp=%b", {out1, busy1, done1}, {b[7], 1'b1, 1'b1});
        end
        for (int i = 6; i >= 0; i--) begin
            tick;
            tests++;
            if ({out1, busy1, done1} !== {b[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL par_b_bit%0d got=%b exp=%b", i, {out1, busy1, done1}, {b[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out1, busy1, done1} !== 3'b110) begin
            fails++; $display("FAIL par_b_parity got=%b exp=110", {out1, busy1, done1});
        end
        tick;
        tests++;
        if ({out1, busy1, done1} !== 3'b001) begin
            fails++; $display("FAIL par_b_done got=%b exp=001", {out1, busy1, done1});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h00; b = 8'hFF;
        do_reset;
        enable = 1'b1; data_in = a; data_valid = 1'b1;
        tick;
        data_in = b;
        for (int i = 7; i >= 0; i--) begin
            tick;
            if (i == 6) data_valid = 1'b0;
            tests++;
            if ({out0, busy0, done0} !== {a[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL b2b_a_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {a[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== {b[7], 1'b1, 1'b1}) begin
            fails++; $display("FAIL b2b_chain got=%b exp=%b", {out0, busy0, done0}, {b[7], 1'b1, 1'b1});
        end
        for (int i = 6; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {b[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL b2b_b_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {b[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b001) begin
            fails++; $display("FAIL b2b_done got=%b exp=001", {out0, busy0, done0});
        end
    endtask

    task automatic test_stall;
        logic [7:0] w;
        w = 8'hC3;
        do_reset;
        enable = 1'b1; data_in = w; data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {w[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL stall_pre_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {w[i], 1'b1, 1'b0});
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {w[3], 1'b1, 1'b0}) begin
                fails++; $display("FAIL stall_hold%0d got=%b exp=%b", k, {out0, busy0, done0}, {w[3], 1'b1, 1'b0});
            end
        end
        enable = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {w[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL stall_post_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {w[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b001) begin
            fails++; $display("FAIL stall_done got=%b exp=001", {out0, busy0, done0});
        end
    endtask

    task automatic test_full_block;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h81; b = 8'h3C;
        do_reset;
        enable = 1'b0; data_in = a; data_valid = 1'b1;
        tick;
        data_in = b;
        for (int k = 0; k < 2; k++) begin
            tick;
            tests++;
            if ({data_ready0, busy0, out0} !== 3'b000) begin
                fails++; $display("FAIL full_wait%0d got=%b exp=000", k, {data_ready0, busy0, out0});
            end
        end
        enable = 1'b1;
        tick;
        tests++;
        if ({out0, busy0, data_ready0} !== {a[7], 1'b1, 1'b1}) begin
            fails++; $display("FAIL full_load got=%b exp=%b", {out0, busy0, data_ready0}, {a[7], 1'b1, 1'b1});
        end
        tick;
        data_valid = 1'b0;
        tests++;
        if ({out0, data_ready0} !== {a[6], 1'b0}) begin
            fails++; $display("FAIL full_accept got=%b exp=%b", {out0, data_ready0}, {a[6], 1'b0});
        end
        for (int i = 5; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {a[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL full_a_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {a[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== {b[7], 1'b1, 1'b1}) begin
            fails++; $display("FAIL full_chain got=%b exp=%b", {out0, busy0, done0}, {b[7], 1'b1, 1'b1});
        end
        for (int i = 6; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {b[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL full_b_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {b[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b001) begin
            fails++; $display("FAIL full_done got=%b exp=001", {out0, busy0, done0});
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] a;
        logic [7:0] w;
        a = 8'hE7; w = 8'h5A;
        do_reset;
        enable = 1'b1; data_in = a; data_valid = 1'b1;
        tick;
        data_in = 8'hFF;
        tick;
        tick;
        data_valid = 1'b0;
        tick;
        tick;
        tick;
        tests++;
        if ({out0, busy0} !== {a[3], 1'b1}) begin
            fails++; $display("FAIL rst_fifth_bit got=%b exp=%b", {out0, busy0}, {a[3], 1'b1});
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({out0, busy0, done0, data_ready0} !== 4'b0001) begin
            fails++; $display("FAIL rst_async got=%b exp=0001", {out0, busy0, done0, data_ready0});
        end
        #1 reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            tests++;
            if ({out0, busy0, done0, data_ready0} !== 4'b0001) begin
                fails++; $display("FAIL rst_idle%0d got=%b exp=0001", k, {out0, busy0, done0, data_ready0});
            end
        end
        data_in = w; data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick;
            tests++;
            if ({out0, busy0, done0} !== {w[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL rst_5a_bit%0d got=%b exp=%b", i, {out0, busy0, done0}, {w[i], 1'b1, 1'b0});
            end
        end
        tick;
        tests++;
        if ({out0, busy0, done0} !== 3'b001) begin
            fails++; $display("FAIL rst_5a_done got=%b exp=001", {out0, busy0, done0});
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        #1 reset = 1'b0;
        #2;
        test_reset;
        test_basic;
        test_parity;
        test_back_to_back;
        test_stall;
        test_full_block;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
